neopixel_chain: RTL and testbench

Parametrised WS2812-style LED strip driver that replaces the single-pixel writer/fixed-colour sequencer pair. It holds a per-pixel colour buffer and generates the one-wire bit timing itself. On a refresh request it streams all pixels back-to-back, then holds the line low for the latch period. It sits directly behind a PMOD output pin, and the user logic writes colours through a simple write port.

---
 rtl/neopixel_chain_if.sv | 33 +++
 rtl/neopixel_chain.sv | 203 ++++++++++++++++++++
 tb/tb_neopixel_chain.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/neopixel_chain_if.sv
// neopixel_chain_if: user-side port bundle of the WS2812 strip driver.
// The master side writes colours and requests frames; the slave side is the
// driver, which returns the serial line and its status flags.
interface neopixel_chain_if #(
  parameter int NUM_PIXELS = 10
);

  localparam int AW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

  logic          i_wr_en;
  logic [AW-1:0] i_wr_addr;
  logic [7:0]    i_wr_red;
  logic [7:0]    i_wr_green;
  logic [7:0]    i_wr_blue;
  logic          i_refresh;
  logic          i_auto;
  logic          o_dout;
  logic          o_busy;
  logic          o_frame_done;

  modport master (
    output i_wr_en, i_wr_addr, i_wr_red, i_wr_green, i_wr_blue,
    output i_refresh, i_auto,
    input  o_dout, o_busy, o_frame_done
  );

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_red, i_wr_green, i_wr_blue,
    input  i_refresh, i_auto,
    output o_dout, o_busy, o_frame_done
  );

endinterface

// File: rtl/neopixel_chain.sv
// neopixel_chain: WS2812-style LED strip driver.
// Holds a GRB colour buffer, streams every pixel MSB-first as fixed-length
// one-wire bit periods, then holds the line low for the latch time. The next
// pixel word is prefetched near the end of the current pixel so that pixels
// follow each other with no gap on the wire.
module neopixel_chain #(
  parameter int NUM_PIXELS = 10,
  parameter int T0H_CYC    = 4,
  parameter int T1H_CYC    = 10,
  parameter int TBIT_CYC   = 15,
  parameter int TRESET_CYC = 960
) (
  input logic          CLK,
  input logic          RST,
  neopixel_chain_if.slave bus
);

  localparam int AW  = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int PHW = (TBIT_CYC > 2) ? $clog2(TBIT_CYC) : 2;
  localparam int LW  = (TRESET_CYC > 1) ? $clog2(TRESET_CYC) : 1;

  localparam logic [PHW-1:0] PH_LAST  = PHW'(TBIT_CYC - 1);
  localparam logic [PHW-1:0] T0H_P    = PHW'(T0H_CYC);
  localparam logic [PHW-1:0] T1H_P    = PHW'(T1H_CYC);
  localparam logic [AW-1:0]  PX_LAST  = AW'(NUM_PIXELS - 1);
  localparam logic [LW-1:0]  LT_LAST  = LW'(TRESET_CYC - 1);
  localparam logic [4:0]     BIT_PF   = 5'd22;
  localparam logic [4:0]     BIT_LAST = 5'd23;

  // Reject timing parameters that cannot produce a valid bit waveform.
  if (!((NUM_PIXELS >= 1) && (T0H_CYC > 0) && (T0H_CYC < T1H_CYC) &&
        (T1H_CYC < TBIT_CYC) && (TRESET_CYC >= 1))) begin : g_param_check
    $error("neopixel_chain: invalid NUM_PIXELS/T0H/T1H/TBIT/TRESET combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  // High time of the current bit, in phase-counter units.
  function automatic logic [PHW-1:0] high_cycles(input logic bit_val);
    return bit_val ? T1H_P : T0H_P;
  endfunction

  // Colour buffer, GRB packed; deliberately outside the reset domain.
  logic [23:0]    mem_r [NUM_PIXELS];
  logic           wr_ok_s;

  state_t         state_r;
  logic           fetch_r;        // second FETCH cycle marker
  logic [PHW-1:0] phase_r;
  logic [4:0]     bit_r;
  logic [AW-1:0]  pix_r;
  logic [LW-1:0]  lat_cnt_r;
  logic [23:0]    shreg_r;        // current pixel, MSB on the wire
  logic [23:0]    pf_r;           // prefetched next pixel word
  logic           pending_r;
  logic           frame_latch_r;  // latch follows a frame (not a reset)
  logic           dout_r;
  logic           busy_r;
  logic           fd_r;

  // Qualify writes: out-of-range pixel indices are dropped.
  always_comb begin
    wr_ok_s = 1'b0;
    if (bus.i_wr_en && (int'(bus.i_wr_addr) < NUM_PIXELS)) begin
      wr_ok_s = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
  end

  // Colour buffer write port; accepted in every state, reads see old data.
  always_ff @(posedge CLK) begin
    if (wr_ok_s) begin
      mem_r[bus.i_wr_addr] <= {bus.i_wr_green, bus.i_wr_red, bus.i_wr_blue};
    end
  end

  // Frame sequencer: counters, shift register and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r       <= ST_LATCH;
      fetch_r       <= 1'b0;
      phase_r       <= {PHW{1'b0}};
      bit_r         <= 5'd0;
      pix_r         <= {AW{1'b0}};
      lat_cnt_r     <= {LW{1'b0}};
      shreg_r       <= 24'd0;
      pf_r          <= 24'd0;
      pending_r     <= 1'b0;
      frame_latch_r <= 1'b0;
      dout_r        <= 1'b0;
      busy_r        <= 1'b1;
      fd_r          <= 1'b0;
    end else begin
      fd_r <= 1'b0;
      // Requests arriving while busy collapse into one pending frame;
      // entering FETCH below overrides this with a clear.
      if (bus.i_refresh && (state_r != ST_IDLE)) begin
        pending_r <= 1'b1;
      end

      case (state_r)
        ST_IDLE: begin
          dout_r <= 1'b0;
          if (bus.i_refresh || bus.i_auto) begin
            state_r   <= ST_FETCH;
            fetch_r   <= 1'b0;
            pending_r <= 1'b0;
            busy_r    <= 1'b1;
          end else begin
            busy_r    <= 1'b0;
          end
        end

        ST_FETCH: begin
          busy_r <= 1'b1;
          if (!fetch_r) begin
            // Capture pixel 0 now; a same-cycle write lands after the read.
            pf_r    <= mem_r[{AW{1'b0}}];
            fetch_r <= 1'b1;
            dout_r  <= 1'b0;
          end else begin
            shreg_r <= pf_r;
            phase_r <= {PHW{1'b0}};
            bit_r   <= 5'd0;
            pix_r   <= {AW{1'b0}};
            state_r <= ST_SEND;
            dout_r  <= 1'b1;  // every bit period opens high
          end
        end

        ST_SEND: begin
          if (phase_r == PH_LAST) begin
            phase_r <= {PHW{1'b0}};
            // Grab the next pixel one bit early so it is ready at bit 23.
            if ((bit_r == BIT_PF) && (pix_r != PX_LAST)) begin
              pf_r <= mem_r[pix_r + AW'(1)];
            end
            if (bit_r == BIT_LAST) begin
              bit_r <= 5'd0;
              if (pix_r == PX_LAST) begin
                state_r       <= ST_LATCH;
                lat_cnt_r     <= {LW{1'b0}};
                frame_latch_r <= 1'b1;
                dout_r        <= 1'b0;
              end else begin
                pix_r   <= pix_r + AW'(1);
                shreg_r <= pf_r;
                dout_r  <= 1'b1;
              end
            end else begin
              bit_r   <= bit_r + 5'd1;
              shreg_r <= {shreg_r[22:0], 1'b0};
              dout_r  <= 1'b1;
            end
          end else begin
            phase_r <= phase_r + PHW'(1);
            dout_r  <= ((phase_r + PHW'(1)) < high_cycles(shreg_r[23]));
          end
        end

        ST_LATCH: begin
          dout_r <= 1'b0;
          if (lat_cnt_r == LT_LAST) begin
            fd_r          <= frame_latch_r;
            frame_latch_r <= 1'b0;
            lat_cnt_r     <= {LW{1'b0}};
            if (pending_r || bus.i_refresh || bus.i_auto) begin
              state_r   <= ST_FETCH;
              fetch_r   <= 1'b0;
              pending_r <= 1'b0;
              busy_r    <= 1'b1;
            end else begin
              state_r   <= ST_IDLE;
              busy_r    <= 1'b0;
            end
          end else begin
            lat_cnt_r <= lat_cnt_r + LW'(1);
            busy_r    <= 1'b1;
          end
        end

        default: begin
          state_r       <= ST_LATCH;
          lat_cnt_r     <= {LW{1'b0}};
          frame_latch_r <= 1'b0;
          dout_r        <= 1'b0;
          busy_r        <= 1'b1;
        end
      endcase
    end
  end

  assign bus.o_dout       = dout_r;
  assign bus.o_busy       = busy_r;
  assign bus.o_frame_done = fd_r;

endmodule

// File: tb/tb_neopixel_chain.sv
// tb_neopixel_chain: directed bench for the strip driver. Expected per-cycle
// outputs are generated from the wire-format rules into a queue; a serial
// decoder recovers pixel words to pin the model with hand-computed literals.
module tb_neopixel_chain;

  localparam int NP   = 2;
  localparam int AW   = 1;
  localparam int T0H  = 2;
  localparam int T1H  = 5;
  localparam int TBIT = 8;
  localparam int TRST = 20;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  neopixel_chain_if #(.NUM_PIXELS(NP)) bus ();

  neopixel_chain #(
    .NUM_PIXELS(NP), .T0H_CYC(T0H), .T1H_CYC(T1H),
    .TBIT_CYC(TBIT), .TRESET_CYC(TRST)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct packed { logic d; logic b; logic f; } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  bit          chk_idle = 1'b0;
  logic [23:0] mdl_buf [NP];

  bit          dec_q[$];
  int          hi_cnt = 0;
  int          len_cnt = 0;
  int          last_len = 0;
  int          fd_cnt = 0;
  bit          counting = 1'b0;
  bit          prev_d = 1'b0;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, want);
    end
  endtask

  // One compare per cycle against the expected-output queue (or idle).
  always @(negedge CLK) begin
    exp_t e;
    logic [2:0] act;
    act = {bus.o_dout, bus.o_busy, bus.o_frame_done};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cycle", 48'(act), 48'(e));
    end else if (chk_idle) begin
      chk("idle", 48'(act), 48'd0);
    end
  end

  // Serial decoder: high-time per bit, frame length rise-to-done, done count.
  always @(negedge CLK) begin
    if (RST) begin
      hi_cnt   = 0;
      counting = 1'b0;
      prev_d   = 1'b0;
    end else begin
      if (counting) begin
        len_cnt++;
        if (bus.o_frame_done) begin
          last_len = len_cnt;
          counting = 1'b0;
        end
      end
      if (bus.o_dout && !prev_d && !counting) begin
        counting = 1'b1;
        len_cnt  = 0;
      end
      if (bus.o_frame_done) fd_cnt++;
      if (bus.o_dout) begin
        hi_cnt++;
      end else if (prev_d) begin
        dec_q.push_back(hi_cnt == T1H);
        hi_cnt = 0;
      end
      prev_d = bus.o_dout;
    end
  end

  task automatic push(input logic d, input logic b, input logic f);
    exp_t e;
    e.d = d; e.b = b; e.f = f;
    exp_q.push_back(e);
  endtask

  // Two fetch cycles, 24*NP bit periods MSB first, then the latch low time.
  task automatic push_frame(input logic [23:0] w0, input logic [23:0] w1, input logic first_fd);
    logic [23:0] w [NP];
    w[0] = w0;
    w[1] = w1;
    push(1'b0, 1'b1, first_fd);
    push(1'b0, 1'b1, 1'b0);
    for (int p = 0; p < NP; p++)
      for (int i = 23; i >= 0; i--)
        for (int ph = 0; ph < TBIT; ph++)
          push(ph < (w[p][i] ? T1H : T0H), 1'b1, 1'b0);
    for (int c = 0; c < TRST; c++) push(1'b0, 1'b1, 1'b0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    bus.i_wr_en    = 1'b1;
    bus.i_wr_addr  = a;
    bus.i_wr_red   = r;
    bus.i_wr_green = g;
    bus.i_wr_blue  = b;
    mdl_buf[a]     = {g, r, b};
    @(negedge CLK); #1;
    bus.i_wr_en    = 1'b0;
  endtask

  task automatic pulse_refresh();
    bus.i_refresh = 1'b1;
    @(negedge CLK); #1;
    bus.i_refresh = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge CLK); #1;
    end
    chk({name, "_drain"}, 48'(exp_q.size()), 48'd0);
    exp_q.delete();
  endtask

  task automatic do_reset(input int hold);
    exp_q.delete();
    RST = 1'b1;
    #1;
    chk("rst_async", 48'({bus.o_dout, bus.o_busy, bus.o_frame_done}), 48'h2);
    for (int i = 0; i < hold; i++) push(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < TRST - 1; i++) push(1'b0, 1'b1, 1'b0);
    chk_idle = 1'b1;
    repeat (hold) @(negedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic check_frame(input string name, input logic [47:0] want);
    logic [47:0] v;
    v = 48'd0;
    chk({name, "_nbits"}, 48'(dec_q.size()), 48'd48);
    for (int i = 0; i < dec_q.size() && i < 48; i++) v = {v[46:0], dec_q[i]};
    chk(name, v, want);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_wr_en    = 1'b0;
    bus.i_wr_addr  = 1'b0;
    bus.i_wr_red   = 8'd0;
    bus.i_wr_green = 8'd0;
    bus.i_wr_blue  = 8'd0;
    bus.i_refresh  = 1'b0;
    bus.i_auto     = 1'b0;

    // Power-on reset latch: busy for TRESET cycles, no done pulse.
    @(negedge CLK); #1;
    do_reset(3);
    wait_drain("rst0");
    repeat (5) @(negedge CLK);
    #1;

    // Basic frame.
    wr(1'b0, 8'h20, 8'h00, 8'h00);
    wr(1'b1, 8'h00, 8'hFF, 8'h01);
    chk("model_pix0", 48'(mdl_buf[0]), 48'h002000);
    chk("model_pix1", 48'(mdl_buf[1]), 48'hFF0001);
    dec_q.delete();
    last_len = -1;
    push_frame(mdl_buf[0], mdl_buf[1], 1'b0);
    push(1'b0, 1'b0, 1'b1);
    pulse_refresh();
    wait_drain("basic");
    check_frame("basic_words", 48'h002000_FF0001);
    chk("frame_len", 48'(last_len), 48'd404);

    // Reset while idle.
    repeat (4) @(negedge CLK);
    #1;
    do_reset(4);
    wait_drain("rst_idle");

    // Write race: pix1 before its capture, pix0 after its capture.
    dec_q.delete();
    push_frame(mdl_buf[0], 24'h008000, 1'b0);
    push(1'b0, 1'b0, 1'b1);
    pulse_refresh();
    repeat (28) @(negedge CLK);
    #1;
    wr(1'b1, 8'h80, 8'h00, 8'h00);
    wr(1'b0, 8'h20, 8'h55, 8'h00);
    wait_drain("race1");
    check_frame("race1_words", 48'h002000_008000);
    chk("model_pix0_g55", 48'(mdl_buf[0]), 48'h552000);
    dec_q.delete();
    push_frame(mdl_buf[0], mdl_buf[1], 1'b0);
    push(1'b0, 1'b0, 1'b1);
    pulse_refresh();
    wait_drain("race2");
    check_frame("race2_words", 48'h552000_008000);

    // Pending: three requests during SEND collapse into one extra frame.
    fd_cnt = 0;
    push_frame(mdl_buf[0], mdl_buf[1], 1'b0);
    push_frame(mdl_buf[0], mdl_buf[1], 1'b1);
    push(1'b0, 1'b0, 1'b1);
    pulse_refresh();
    repeat (50) @(negedge CLK);
    #1;
    pulse_refresh();
    repeat (30) @(negedge CLK);
    #1;
    pulse_refresh();
    repeat (30) @(negedge CLK);
    #1;
    pulse_refresh();
    wait_drain("pending");
    chk("pending_done_cnt", 48'(fd_cnt), 48'd2);

    // Auto mode for three frames, dropped during the third.
    fd_cnt = 0;
    push_frame(mdl_buf[0], mdl_buf[1], 1'b0);
    push_frame(mdl_buf[0], mdl_buf[1], 1'b1);
    push_frame(mdl_buf[0], mdl_buf[1], 1'b1);
    push(1'b0, 1'b0, 1'b1);
    bus.i_auto = 1'b1;
    repeat (900) @(negedge CLK);
    #1;
    bus.i_auto = 1'b0;
    wait_drain("auto");
    chk("auto_done_cnt", 48'(fd_cnt), 48'd3);

    // Reset during pixel 1 bit 10, then a clean frame.
    push_frame(mdl_buf[0], mdl_buf[1], 1'b0);
    pulse_refresh();
    repeat (274) @(negedge CLK);
    #1;
    fd_cnt = 0;
    do_reset(3);
    wait_drain("rst_mid");
    chk("rst_mid_no_done", 48'(fd_cnt), 48'd0);
    dec_q.delete();
    push_frame(mdl_buf[0], mdl_buf[1], 1'b0);
    push(1'b0, 1'b0, 1'b1);
    pulse_refresh();
    wait_drain("post_rst");
    check_frame("post_rst_words", 48'h552000_008000);

    repeat (5) @(negedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
